text_cell_fetch: RTL and testbench

TEXT_CELL_FETCH -- requirements
Module: text_cell_fetch

---
 rtl/text_cell_fetch_if.sv | 29 ++
 rtl/text_cell_fetch.sv | 152 +++++++++++++++
 tb/tb_text_cell_fetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/text_cell_fetch_if.sv
// Text cell fetch bus: pixel coordinates and text-buffer writes in,
// glyph code and aligned coordinates out.
interface text_cell_fetch_if;
  logic [11:0] pixel_row;
  logic [11:0] pixel_column;
  logic        video_on;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic        clr_req;
  logic [3:0]  char_sel;
  logic [11:0] pixel_row_d;
  logic [11:0] pixel_column_d;
  logic        video_on_d;
  logic        clr_busy;
  logic        wr_drop;

  // Video timing / CPU side that drives the fetch block
  modport master (
    output pixel_row, pixel_column, video_on, wr_en, wr_addr, wr_data, clr_req,
    input  char_sel, pixel_row_d, pixel_column_d, video_on_d, clr_busy, wr_drop
  );

  // The fetch block itself
  modport slave (
    input  pixel_row, pixel_column, video_on, wr_en, wr_addr, wr_data, clr_req,
    output char_sel, pixel_row_d, pixel_column_d, video_on_d, clr_busy, wr_drop
  );
endinterface

// File: rtl/text_cell_fetch.sv
// Text-mode character fetch: 40x30 grid of 16x16 cells over a 640x480
// raster. Two-stage read pipeline from a 1200x4 text buffer, with a
// hardware clear sweep that runs after reset and on request.
module text_cell_fetch (
  input logic              vga_clk,
  input logic              rst_n,
  text_cell_fetch_if.slave bus
);

  localparam int unsigned COLS     = 40;
  localparam int unsigned ROWS     = 30;
  localparam int unsigned CELL     = 16;
  localparam int unsigned NCELLS   = COLS * ROWS;
  localparam int unsigned H_ACTIVE = COLS * CELL;
  localparam int unsigned V_ACTIVE = ROWS * CELL;
  localparam int unsigned CELL_SH  = $clog2(CELL);
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned COORD_W  = 12;
  localparam int unsigned CIDX_W   = 6;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
  logic                wr_drop_nxt;
  logic                clr_busy_nxt;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [CODE_W-1:0]   mem_wdata;
  logic [CODE_W-1:0]   text_mem [NCELLS];

  logic [CIDX_W-1:0]   cell_row, cell_col;
  logic [ADDR_W-1:0]   rd_idx;
  logic                rd_ok;
  logic                wr_addr_ok;

  logic [ADDR_W-1:0]   rd_idx_q;
  logic                rd_ok_q;
  logic [COORD_W-1:0]  row_q, col_q;
  logic                von_q;

  // Cell index from the current raster position; out-of-range never reads
  always_comb begin
    cell_row   = CIDX_W'(bus.pixel_row >> CELL_SH);
    cell_col   = CIDX_W'(bus.pixel_column >> CELL_SH);
    rd_ok      = bus.video_on
                 && (bus.pixel_row < COORD_W'(V_ACTIVE))
                 && (bus.pixel_column < COORD_W'(H_ACTIVE));
    rd_idx     = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
    wr_addr_ok = bus.wr_addr < ADDR_W'(NCELLS);
  end

  // FSM state and clear counter register
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      bus.clr_busy <= 1'b1;
      bus.wr_drop  <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_cnt      <= clr_cnt_nxt;
      bus.clr_busy <= clr_busy_nxt;
      bus.wr_drop  <= wr_drop_nxt;
    end
  end

  // Next state, buffer write port selection and write-drop detection
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_waddr   = bus.wr_addr;
    mem_wdata   = bus.wr_data;
    wr_drop_nxt = 1'b0;
    unique case (state)
      CLEAR: begin
        // Sweep owns the write port; any host write is lost
        mem_we      = 1'b1;
        mem_waddr   = clr_cnt;
        mem_wdata   = '0;
        wr_drop_nxt = bus.wr_en;
        if (clr_cnt == ADDR_W'(NCELLS - 1)) begin
          state_nxt   = IDLE;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.wr_en) begin
          if (wr_addr_ok) mem_we = 1'b1;
          else            wr_drop_nxt = 1'b1;
        end
        // A simultaneous write still lands; the sweep then overwrites it
        if (bus.clr_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
    clr_busy_nxt = (state_nxt == CLEAR);
  end

  // Text buffer write port; contents deliberately not reset
  always_ff @(posedge vga_clk) begin
    if (mem_we) text_mem[mem_waddr] <= mem_wdata;
  end

  // Stage 1: capture index, range qualifier and raw coordinates
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q <= '0;
      rd_ok_q  <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      von_q    <= 1'b0;
    end else begin
      rd_idx_q <= rd_ok ? rd_idx : '0;
      rd_ok_q  <= rd_ok;
      row_q    <= bus.pixel_row;
      col_q    <= bus.pixel_column;
      von_q    <= bus.video_on;
    end
  end

  // Stage 2: buffer read (old data on same-address write), masked during sweep
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.char_sel       <= '0;
      bus.pixel_row_d    <= '0;
      bus.pixel_column_d <= '0;
      bus.video_on_d     <= 1'b0;
    end else begin
      if (rd_ok_q && (state == IDLE)) bus.char_sel <= text_mem[rd_idx_q];
      else                            bus.char_sel <= '0;
      bus.pixel_row_d    <= row_q;
      bus.pixel_column_d <= col_q;
      bus.video_on_d     <= von_q;
    end
  end

endmodule

// File: tb/tb_text_cell_fetch.sv
// Bench for text_cell_fetch: directed scenarios plus random traffic,
// checked every cycle against a cell-level reference model.
module tb_text_cell_fetch;

  localparam int NC = 1200;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;

  text_cell_fetch_if bus ();

  text_cell_fetch dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  int   ref_mem [NC];
  bit   ref_busy;
  int   busy_left;
  bit   p_ok;
  int   p_idx;
  int   p_row, p_col;
  bit   p_v;
  int   e_char, e_row, e_col, e_von, e_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    ref_busy  = 1'b1;
    busy_left = NC;
    p_ok = 1'b0; p_idx = 0; p_row = 0; p_col = 0; p_v = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 0;
  endtask

  // One clock: drive inputs, advance model at the edge, compare at the falling edge
  task automatic tick(input int r, input int c, input bit v,
                      input bit we, input int wa, input int wd, input bit clr);
    bus.pixel_row    = 12'(r);
    bus.pixel_column = 12'(c);
    bus.video_on     = v;
    bus.wr_en        = we;
    bus.wr_addr      = 11'(wa);
    bus.wr_data      = 4'(wd);
    bus.clr_req      = clr;
    @(posedge vga_clk);
    e_char = (p_ok && !ref_busy) ? ref_mem[p_idx] : 0;
    e_row  = p_row;
    e_col  = p_col;
    e_von  = int'(p_v);
    e_drop = int'(we && (ref_busy || wa >= NC));
    if (ref_busy) begin
      busy_left--;
      if (busy_left == 0) ref_busy = 1'b0;
    end else begin
      if (we && wa < NC) ref_mem[wa] = wd;
      if (clr) begin
        ref_busy  = 1'b1;
        busy_left = NC;
        foreach (ref_mem[i]) ref_mem[i] = 0;
      end
    end
    p_ok  = v && (r < 480) && (c < 640);
    p_idx = (r / 16) * 40 + (c / 16);
    p_row = r; p_col = c; p_v = v;
    @(negedge vga_clk);
    check("char_sel",       bus.char_sel,       e_char);
    check("pixel_row_d",    bus.pixel_row_d,    e_row);
    check("pixel_column_d", bus.pixel_column_d, e_col);
    check("video_on_d",     bus.video_on_d,     e_von);
    check("wr_drop",        bus.wr_drop,        e_drop);
    check("clr_busy",       bus.clr_busy,       ref_busy);
  endtask

  task automatic idle();
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic rand_tick(input bit clr);
    tick($urandom_range(0, 700), $urandom_range(0, 800), ($urandom_range(0, 4) != 0),
         ($urandom_range(0, 1) == 1), $urandom_range(0, 1299), $urandom_range(0, 15), clr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char"}, bus.char_sel,       0);
    check({tag, "_row"},  bus.pixel_row_d,    0);
    check({tag, "_col"},  bus.pixel_column_d, 0);
    check({tag, "_von"},  bus.video_on_d,     0);
    check({tag, "_drop"}, bus.wr_drop,        0);
    check({tag, "_busy"}, bus.clr_busy,       1);
  endtask

  // Assert reset away from the edge, check asynchronous clearing, release
  task automatic do_reset(input int hold);
    @(negedge vga_clk);
    #1 rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.clr_req = 1'b0; bus.video_on = 1'b0;
    bus.pixel_row = '0; bus.pixel_column = '0; bus.wr_addr = '0; bus.wr_data = '0;
    #1 check_reset_outputs("rst_async");
    repeat (hold) @(negedge vga_clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    model_reset();
  endtask

  // Count cycles from sweep start until clr_busy falls; optional clr_req at tick clr_at
  task automatic measure_sweep(input string tag, input int n0, input int clr_at);
    int n;
    n = n0;
    do begin
      rand_tick(n == clr_at);
      n++;
    end while (bus.clr_busy === 1'b1 && n < 1500);
    check(tag, n, NC);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.clr_busy === 1'b1 && n < 1500) begin
      idle();
      n++;
    end
    check("wait_idle", bus.clr_busy, 0);
  endtask

  initial begin
    bus.pixel_row = '0; bus.pixel_column = '0; bus.video_on = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.clr_req = 1'b0;

    // Power-up: reset, full sweep, whole screen reads zero
    repeat (2) @(negedge vga_clk);
    do_reset(3);
    measure_sweep("powerup_sweep_len", 0, -1);
    for (int rr = 0; rr < 30; rr++)
      for (int cc = 0; cc < 40; cc++)
        tick(rr * 16 + $urandom_range(0, 15), cc * 16 + $urandom_range(0, 15), 1'b1,
             1'b0, 0, 0, 1'b0);
    idle(); idle();

    // Write code 5 at cell 41, read it at (16,16)
    tick(0, 0, 1'b0, 1'b1, 41, 5, 1'b0);
    tick(16, 16, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("rw_char", bus.char_sel, 5);
    check("rw_row",  bus.pixel_row_d, 16);
    check("rw_col",  bus.pixel_column_d, 16);
    check("rw_von",  bus.video_on_d, 1);

    // Bounds: rejected address, last cell, off-screen and blanked reads
    tick(0, 0, 1'b0, 1'b1, 1200, 7, 1'b0);
    check("drop_1200", bus.wr_drop, 1);
    idle();
    check("drop_pulse_end", bus.wr_drop, 0);
    tick(0, 0, 1'b0, 1'b1, 1199, 3, 1'b0);
    tick(479, 639, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("last_cell", bus.char_sel, 3);
    tick(480, 16, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("row_480", bus.char_sel, 0);
    tick(16, 640, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("col_640", bus.char_sel, 0);
    tick(16, 16, 1'b0, 1'b0, 0, 0, 1'b0);
    idle();
    check("video_off", bus.char_sel, 0);

    // Hazard: read and write cell 100 in the same cycle
    tick(0, 0, 1'b0, 1'b1, 100, 4, 1'b0);
    tick(32, 320, 1'b1, 1'b0, 0, 0, 1'b0);
    tick(0, 0, 1'b0, 1'b1, 100, 9, 1'b0);
    check("hazard_old", bus.char_sel, 4);
    tick(32, 320, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("hazard_new", bus.char_sel, 9);

    // Clear: busy next cycle, write dropped, mid-sweep request ignored
    tick(0, 0, 1'b0, 1'b1, 5, 6, 1'b0);
    tick(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    check("clr_busy_start", bus.clr_busy, 1);
    tick(0, 0, 1'b0, 1'b1, 5, 12, 1'b0);
    check("clr_write_drop", bus.wr_drop, 1);
    measure_sweep("clr_sweep_len", 1, 500);
    tick(0, 80, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("clr_data_lost", bus.char_sel, 0);

    // Random traffic with occasional clear requests
    for (int i = 0; i < 2500; i++) rand_tick($urandom_range(0, 799) == 0);
    wait_idle();

    // Reset at sweep cycle 600, then a full sweep from address 0
    tick(0, 0, 1'b0, 1'b1, 41, 8, 1'b1);
    for (int i = 1; i < 600; i++) rand_tick(1'b0);
    do_reset(2);
    measure_sweep("rst_mid_sweep_len", 0, -1);
    tick(16, 16, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
    check("rst_mid_cell41", bus.char_sel, 0);
    for (int i = 0; i < 300; i++) rand_tick(1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
